eth_vlan_parser: RTL and testbench

Parametrised Ethernet L2 header parser with 802.1Q/802.1ad VLAN tag extraction. It sits at the head of the parser chain, in the same slot as the untagged Ethernet parser. It forwards the byte-packed beat stream to the IPv4 parser with one cycle of delay. It publishes DA/SA, up to MAX_VLAN_TAGS tag control words, the inner EtherType and the header length. It flags frames that end before their header is complete.

---
 rtl/eth_vlan_parser.sv | 170 +++++++++++++++++
 tb/tb_eth_vlan_parser.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_vlan_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_vlan_parser: Ethernet L2 header parser with 802.1Q/802.1ad tag        |
// | extraction and a one-cycle stream pass-through.                           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module eth_vlan_parser #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          MAX_VLAN_TAGS = 2,
  parameter logic [15:0] TPID_A        = 16'h8100,
  parameter logic [15:0] TPID_B        = 16'h88A8,
  localparam int         NB            = DATA_WIDTH / 8,
  localparam int         IW            = $clog2(NB + 1),
  localparam int         VW            = $clog2(MAX_VLAN_TAGS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        tdata_in,
  input  logic [IW-1:0]                idx_in,
  input  logic                         data_valid_in,
  input  logic                         last_flag_in,
  output logic [DATA_WIDTH-1:0]        tdata_out,
  output logic [IW-1:0]                idx_out,
  output logic                         data_valid_out,
  output logic                         last_flag_out,
  output logic [47:0]                  dst_mac,
  output logic [47:0]                  src_mac,
  output logic [15:0]                  eth_type,
  output logic [16*MAX_VLAN_TAGS-1:0]  vlan_tci,
  output logic [VW-1:0]                vlan_count,
  output logic [7:0]                   hdr_len,
  output logic                         hdr_valid,
  output logic                         hdr_ready,
  output logic                         short_frame_err
);

  localparam logic [0:0] S_HDR   = 1'b0;
  localparam logic [0:0] S_BODY  = 1'b1;
  localparam int         MAX_HDR = 14 + 4 * MAX_VLAN_TAGS;

  logic [0:0]                  state;
  logic [7:0]                  cnt, cnt_n;
  logic [47:0]                 da_sh, da_n, sa_sh, sa_n;
  logic [15:0]                 type_sh, type_n;
  logic [16*MAX_VLAN_TAGS-1:0] tci_sh, tci_n;
  logic [VW-1:0]               tags_sh, tags_n;
  logic                        done_n;
  logic [7:0]                  byte_v;
  int                          pos_v;
  int                          grp_v;

  // Walk every valid byte of the beat in wire order. After SA the header is a
  // sequence of 4-byte groups: type word, then a TCI if that type was a TPID.
  always_comb begin
    da_n   = da_sh;
    sa_n   = sa_sh;
    type_n = type_sh;
    tci_n  = tci_sh;
    tags_n = tags_sh;
    cnt_n  = cnt;
    done_n = 1'b0;
    byte_v = 8'd0;
    pos_v  = 0;
    grp_v  = 0;
    for (int i = 0; i < NB; i++) begin
      if ((IW'(i) < idx_in) && !done_n && (state == S_HDR)) begin
        byte_v = tdata_in[i*8 +: 8];
        pos_v  = int'(cnt_n);
        if (pos_v < 6) begin
          da_n[(5 - pos_v)*8 +: 8] = byte_v;
        end else if (pos_v < 12) begin
          sa_n[(11 - pos_v)*8 +: 8] = byte_v;
        end else begin
          grp_v = (pos_v - 12) / 4;
          case ((pos_v - 12) % 4)
            0: type_n[15:8] = byte_v;
            1: begin
              type_n[7:0] = byte_v;
              if (((type_n == TPID_A) || (type_n == TPID_B)) &&
                  (int'(tags_n) < MAX_VLAN_TAGS))
                tags_n = tags_n + VW'(1);
              else
                done_n = 1'b1;
            end
            2:       tci_n[grp_v*16 + 8 +: 8] = byte_v;
            default: tci_n[grp_v*16 +: 8]     = byte_v;
          endcase
        end
        if (int'(cnt_n) < MAX_HDR) cnt_n = cnt_n + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_out       <= '0;
      idx_out         <= '0;
      data_valid_out  <= 1'b0;
      last_flag_out   <= 1'b0;
      dst_mac         <= '0;
      src_mac         <= '0;
      eth_type        <= '0;
      vlan_tci        <= '0;
      vlan_count      <= '0;
      hdr_len         <= '0;
      hdr_valid       <= 1'b0;
      hdr_ready       <= 1'b0;
      short_frame_err <= 1'b0;
      state           <= S_HDR;
      cnt             <= '0;
      da_sh           <= '0;
      sa_sh           <= '0;
      type_sh         <= '0;
      tci_sh          <= '0;
      tags_sh         <= '0;
    end else begin
      tdata_out       <= tdata_in;
      idx_out         <= idx_in;
      data_valid_out  <= data_valid_in;
      last_flag_out   <= last_flag_in;
      hdr_valid       <= 1'b0;
      short_frame_err <= 1'b0;
      // The clear is overridden below when a new header completes this cycle.
      if (data_valid_out && last_flag_out) hdr_ready <= 1'b0;
      if (data_valid_in) begin
        if (state == S_HDR) begin
          if (done_n) begin
            dst_mac    <= da_n;
            src_mac    <= sa_n;
            eth_type   <= type_n;
            vlan_tci   <= tci_n;
            vlan_count <= tags_n;
            hdr_len    <= 8'(14 + 4 * int'(tags_n));
            hdr_valid  <= 1'b1;
            hdr_ready  <= 1'b1;
          end else if (last_flag_in) begin
            short_frame_err <= 1'b1;
          end
          if (last_flag_in) begin
            state   <= S_HDR;
            cnt     <= '0;
            da_sh   <= '0;
            sa_sh   <= '0;
            type_sh <= '0;
            tci_sh  <= '0;
            tags_sh <= '0;
          end else begin
            state   <= done_n ? S_BODY : S_HDR;
            cnt     <= cnt_n;
            da_sh   <= da_n;
            sa_sh   <= sa_n;
            type_sh <= type_n;
            tci_sh  <= tci_n;
            tags_sh <= tags_n;
          end
        end else if (last_flag_in) begin
          state   <= S_HDR;
          cnt     <= '0;
          da_sh   <= '0;
          sa_sh   <= '0;
          type_sh <= '0;
          tci_sh  <= '0;
          tags_sh <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_vlan_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_eth_vlan_parser: directed bench with a header scoreboard.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_eth_vlan_parser;

  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] tdata_in;
  logic [3:0]    idx_in;
  logic          data_valid_in;
  logic          last_flag_in;
  logic [DW-1:0] tdata_out;
  logic [3:0]    idx_out;
  logic          data_valid_out;
  logic          last_flag_out;
  logic [47:0]   dst_mac;
  logic [47:0]   src_mac;
  logic [15:0]   eth_type;
  logic [31:0]   vlan_tci;
  logic [1:0]    vlan_count;
  logic [7:0]    hdr_len;
  logic          hdr_valid;
  logic          hdr_ready;
  logic          short_frame_err;

  eth_vlan_parser #(
    .DATA_WIDTH   (DW),
    .MAX_VLAN_TAGS(2),
    .TPID_A       (16'h8100),
    .TPID_B       (16'h88A8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tdata_in       (tdata_in),
    .idx_in         (idx_in),
    .data_valid_in  (data_valid_in),
    .last_flag_in   (last_flag_in),
    .tdata_out      (tdata_out),
    .idx_out        (idx_out),
    .data_valid_out (data_valid_out),
    .last_flag_out  (last_flag_out),
    .dst_mac        (dst_mac),
    .src_mac        (src_mac),
    .eth_type       (eth_type),
    .vlan_tci       (vlan_tci),
    .vlan_count     (vlan_count),
    .hdr_len        (hdr_len),
    .hdr_valid      (hdr_valid),
    .hdr_ready      (hdr_ready),
    .short_frame_err(short_frame_err)
  );

  typedef struct {
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] et;
    logic [31:0] tci;
    logic [1:0]  cnt;
    logic [7:0]  hl;
    logic [63:0] beat;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  exp_t       got;
  int         cur_hlen = 14;
  int         checks = 0;
  int         failures = 0;
  int         exp_shorts = 0;
  int         seen_shorts = 0;
  logic [7:0] fb [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int s, input int n);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[i*8 +: 8] = fb[s + i];
    return d;
  endfunction

  // Lays out a frame in fb and derives the expected header from the tag list.
  task automatic build(input logic [47:0] da, input logic [47:0] sa, input int nt,
                       input logic [47:0] tps, input logic [47:0] tcs, input logic [15:0] et);
    int p;
    int n;
    for (int i = 0; i < 64; i++) fb[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 6; i++) begin
      fb[i]     = da[47 - 8*i -: 8];
      fb[6 + i] = sa[47 - 8*i -: 8];
    end
    p = 12;
    for (int k = 0; k < nt; k++) begin
      fb[p]     = tps[k*16 + 8 +: 8];
      fb[p + 1] = tps[k*16 +: 8];
      fb[p + 2] = tcs[k*16 + 8 +: 8];
      fb[p + 3] = tcs[k*16 +: 8];
      p += 4;
    end
    fb[p]     = et[15:8];
    fb[p + 1] = et[7:0];
    n = (nt > 2) ? 2 : nt;
    cur.da  = da;
    cur.sa  = sa;
    cur.et  = (nt > 2) ? tps[47:32] : et;
    cur.tci = '0;
    if (n >= 1) cur.tci[15:0]  = tcs[15:0];
    if (n == 2) cur.tci[31:16] = tcs[31:16];
    cur.cnt  = 2'(n);
    cur.hl   = 8'(14 + 4*n);
    cur.beat = '0;
    cur_hlen = 14 + 4*n;
  endtask

  task automatic drive(input logic [63:0] d, input int n, input logic last);
    tdata_in      = d;
    idx_in        = 4'(n);
    data_valid_in = 1'b1;
    last_flag_in  = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tdata_in      = '0;
    idx_in        = '0;
    data_valid_in = 1'b0;
    last_flag_in  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Beat k carries sz[k*4 +: 4] bytes.
  task automatic send_frame(input int nb, input logic [31:0] sz, input bit gaps, input bit chk_gap);
    int   pos;
    int   n;
    exp_t t;
    pos = 0;
    for (int k = 0; k < nb; k++) begin
      n = int'(sz[k*4 +: 4]);
      if ((cur_hlen - 1 >= pos) && (cur_hlen - 1 < pos + n)) begin
        t      = cur;
        t.beat = mk(pos, n);
        q.push_back(t);
      end
      drive(mk(pos, n), n, k == nb - 1);
      if (chk_gap && k == 0) check("ready_gap", hdr_ready, 0);
      pos += n;
      if (gaps) idle(1);
    end
    if (pos < cur_hlen) exp_shorts++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_valid) begin
        if (q.size() == 0) begin
          check("hdr_unexpected", hdr_valid, 0);
        end else begin
          got = q.pop_front();
          check("dst_mac", dst_mac, got.da);
          check("src_mac", src_mac, got.sa);
          check("eth_type", eth_type, got.et);
          check("vlan_tci", vlan_tci, got.tci);
          check("vlan_count", vlan_count, got.cnt);
          check("hdr_len", hdr_len, got.hl);
          check("hdr_align", tdata_out, got.beat);
          check("hdr_ready_w_valid", hdr_ready, 1);
        end
      end
      if (short_frame_err) begin
        seen_shorts++;
        check("short_align", last_flag_out, 1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle(3);
    check("rst_valid_out", data_valid_out, 0);
    check("rst_dst", dst_mac, 0);
    check("rst_hdr_len", hdr_len, 0);
    check("rst_ready", hdr_ready, 0);
    rst_n = 1'b1;
    idle(2);

    // Untagged
    build(48'h000102030405, 48'h060708090A0B, 0, 48'h0, 48'h0, 16'h0800);
    send_frame(3, 32'h888, 0, 0);
    check("t1_ready_last", hdr_ready, 1);
    idle(1);
    check("t1_ready_after", hdr_ready, 0);

    // Single C-tag; header ends on the last beat
    build(48'h111111111111, 48'h222222222222, 1, 48'h8100, 48'h6064, 16'h86DD);
    send_frame(3, 32'h888, 0, 0);
    check("t2_valid_on_last", hdr_valid, 1);
    check("t2_ready_on_last", hdr_ready, 1);
    check("t2_last_out", last_flag_out, 1);
    idle(1);
    check("t2_ready_after", hdr_ready, 0);
    check("t2_no_err", seen_shorts, 0);

    // QinQ with a third tag
    build(48'hAABBCCDDEEFF, 48'h102030405060, 3, 48'h8100_8100_88A8, 48'h0030_0020_0010, 16'h0800);
    send_frame(4, 32'h8888, 0, 0);
    idle(2);

    // Short frame, then untagged 2-beat frame
    send_frame(1, 32'h8, 0, 0);
    idle(1);
    check("short_seen", seen_shorts, 1);
    check("short_keep_dst", dst_mac, 48'hAABBCCDDEEFF);
    check("short_keep_type", eth_type, 16'h8100);
    check("short_keep_cnt", vlan_count, 2);
    build(48'h0A0B0C0D0E0F, 48'h010203040506, 0, 48'h0, 48'h0, 16'h0806);
    send_frame(2, 32'h88, 0, 0);
    idle(2);

    // Ragged beats with invalid cycles interleaved
    build(48'h000102030405, 48'h060708090A0B, 0, 48'h0, 48'h0, 16'h0800);
    send_frame(5, 32'h81503, 1, 0);
    idle(2);

    // Reset mid-frame
    build(48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 0, 48'h0, 48'h0, 16'h0800);
    drive(mk(0, 8), 8, 0);
    tdata_in      = '0;
    idx_in        = '0;
    data_valid_in = 1'b0;
    rst_n         = 1'b0;
    #1;
    check("mid_rst_tdata", tdata_out, 0);
    check("mid_rst_valid", data_valid_out, 0);
    check("mid_rst_dst", dst_mac, 0);
    check("mid_rst_src", src_mac, 0);
    check("mid_rst_type", eth_type, 0);
    check("mid_rst_tci", vlan_tci, 0);
    check("mid_rst_cnt", vlan_count, 0);
    check("mid_rst_len", hdr_len, 0);
    check("mid_rst_ready", hdr_ready, 0);
    check("mid_rst_short", short_frame_err, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back: untagged then tagged, no idle between
    build(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 0, 48'h0, 48'h0, 16'h0800);
    send_frame(3, 32'h888, 0, 0);
    check("b2b_ready_a_last", hdr_ready, 1);
    build(48'h0E0E0E0E0E0E, 48'h0F0F0F0F0F0F, 1, 48'h88A8, 48'hE123, 16'h0800);
    send_frame(3, 32'h888, 0, 1);
    check("b2b_ready_b", hdr_ready, 1);
    idle(3);

    check("queue_drained", q.size(), 0);
    check("short_count", seen_shorts, exp_shorts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
